avion_mem_responder: RTL

- Memory-side responder for the avion_cpu bus (MAR/MDRIn/RAMWr/MDROut): 64x10 single-port word RAM with one-cycle registered read.
- Adds a host loader port (valid/ready) to program and inspect memory while the CPU is held in reset.
- Optionally zero-fills memory after reset.
- Sits between avion_cpu and the board top. The loader is driven by a UART/switch front end.

---
 rtl/avion_pkg.sv | 27 ++
 rtl/avion_spram.sv | 43 ++++
 rtl/avion_mem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/avion_pkg.sv
// avion_pkg: shared definitions for the avion CPU memory slice.
//   - default bus widths (word address / data word)
//   - instruction opcodes (upper 4 bits of a 10-bit word, operand address in the lower 6)
//   - responder FSM state encoding
package avion_pkg;

    localparam int unsigned AVION_AW = 6;
    localparam int unsigned AVION_DW = 10;

    localparam logic [3:0] OP_LOD = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JMZ = 4'd7;
    localparam logic [3:0] OP_NOP = 4'd8;
    localparam logic [3:0] OP_HLT = 4'd9;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_LOAD
    } avion_state_e;

endpackage

// File: rtl/avion_spram.sv
// avion_spram: DEPTH x DATA_WIDTH single-port RAM, synchronous read-before-write.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset of the read register only (array is not reset)
//   i_we     in   write enable
//   i_re     in   read enable; read register holds when low
//   i_addr   in   word address
//   i_wdata  in   write data
//   o_rdata  out  registered read data (old contents on same-address write)
module avion_spram #(
    parameter int unsigned ADDRESS_WIDTH = 6,
    parameter int unsigned DATA_WIDTH    = 10,
    parameter int unsigned DEPTH         = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [ADDRESS_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/avion_mem_responder.sv
// avion_mem_responder: memory-side responder for the avion CPU bus with a host loader port.
// Owns a single-port RAM and arbitrates it between an optional post-reset zero-fill (CLEAR),
// the CPU (RUN) and a host loader (LOAD). The CPU is held in reset whenever it does not own memory.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cpu_addr/wdata/we         CPU MAR / MDRIn / RAMWr
//   cpu_rdata                 CPU MDROut (registered, 1-cycle latency)
//   cpu_rst                   registered reset to the CPU
//   load_req                  host requests memory ownership (level)
//   ld_valid/ld_ready         loader command handshake
//   ld_we/ld_addr/ld_wdata    loader command: 1 = write, 0 = read
//   ld_rvalid/ld_rdata        loader read response, one cycle after an accepted read
//   busy                      high while zero-filling
module avion_mem_responder
    import avion_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = AVION_AW,
    parameter int unsigned DATA_WIDTH     = AVION_DW,
    parameter int unsigned DEPTH          = 64,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    input  logic                     cpu_we,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_rst,
    input  logic                     load_req,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic                     ld_we,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]    ld_wdata,
    output logic                     ld_rvalid,
    output logic [DATA_WIDTH-1:0]    ld_rdata,
    output logic                     busy
);

    localparam avion_state_e       RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [ADDRESS_WIDTH:0] CLR_LAST = (ADDRESS_WIDTH + 1)'(DEPTH - 1);

    avion_state_e              r_state;
    avion_state_e              w_next;
    logic [ADDRESS_WIDTH:0]    r_clr_cnt;
    logic                      r_rvalid;
    logic                      r_cpu_rst;
    logic                      w_accept;
    logic                      w_ram_we;
    logic                      w_ram_re;
    logic [ADDRESS_WIDTH-1:0]  w_ram_addr;
    logic [DATA_WIDTH-1:0]     w_ram_wdata;
    logic [DATA_WIDTH-1:0]     w_rd_q;

    assign ld_ready = (r_state == ST_LOAD);
    assign w_accept = ld_valid & ld_ready;
    assign busy     = (r_state == ST_CLEAR);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == CLR_LAST) w_next = load_req ? ST_LOAD : ST_RUN;
            ST_RUN:   if (load_req) w_next = ST_LOAD;
            ST_LOAD:  if (!load_req && !w_accept) w_next = ST_RUN;
            default:  w_next = RESET_STATE;
        endcase
    end

    // Port mux. A cycle with rst asserted never writes, so reset also aborts a pending write.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = cpu_addr;
        w_ram_wdata = cpu_wdata;
        case (r_state)
            ST_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_clr_cnt[ADDRESS_WIDTH-1:0];
                w_ram_wdata = '0;
            end
            ST_RUN: begin
                w_ram_we = cpu_we;
                w_ram_re = 1'b1;
            end
            ST_LOAD: begin
                w_ram_we    = w_accept & ld_we;
                w_ram_re    = w_accept & ~ld_we;
                w_ram_addr  = ld_addr;
                w_ram_wdata = ld_wdata;
            end
            default: ;
        endcase
        if (rst) w_ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RESET_STATE;
            r_clr_cnt <= '0;
            r_rvalid  <= 1'b0;
            r_cpu_rst <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
            r_rvalid  <= w_accept & ~ld_we;
            // CPU leaves reset on the very edge that hands it the memory.
            r_cpu_rst <= (w_next != ST_RUN);
        end
    end

    avion_spram #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .DEPTH         (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_rd_q)
    );

    assign cpu_rdata = w_rd_q;
    assign ld_rdata  = w_rd_q;
    assign ld_rvalid = r_rvalid;
    assign cpu_rst   = r_cpu_rst;

endmodule
